sha256_msg_loader: RTL and testbench

- Upstream feeder for the SHA-256 compression core.
- Streams NUM_OF_WORDS 32-bit message words out of word-addressed memory, starting at message_addr, with pipelined reads.
- Assembles them into the 16-word block vector the core consumes on its mem_read_data[16] input.
- Holds the block under a valid/ready handshake until the core accepts it. Zero-fills unused words; the core performs SHA padding itself.

---
 rtl/sha256_pkg.sv | 22 ++
 rtl/sha256_msg_loader_if.sv | 25 ++
 rtl/sha256_rd_pipe.sv | 33 +++
 rtl/sha256_msg_loader.sv | 90 +++++++++
 tb/tb_sha256_msg_loader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// sha256_pkg: shared types/constants for the SHA-256 message loader | Rev 1.0
// ============================================================================
package sha256_pkg;

  localparam int BLOCK_WORDS = 16;
  localparam int MAX_MEM_LAT = 4;
  localparam int CNT_W       = $clog2(BLOCK_WORDS + 1);

  typedef logic [31:0] word_t;
  typedef word_t [BLOCK_WORDS-1:0] block_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } ldr_state_t;

endpackage
`default_nettype wire

// File: rtl/sha256_msg_loader_if.sv
`default_nettype none
// ============================================================================
// sha256_msg_loader_if: memory read bus + block valid/ready bundle | Rev 1.0
// ============================================================================
interface sha256_msg_loader_if;
  import sha256_pkg::*;

  logic        mem_rd_en;
  logic [15:0] mem_addr;
  word_t       mem_read_data;
  block_t      block_data;
  logic        block_valid;
  logic        block_ready;

  modport master (
    output mem_rd_en, mem_addr, block_data, block_valid,
    input  mem_read_data, block_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, block_data, block_valid,
    output mem_read_data, block_ready
  );
endinterface
`default_nettype wire

// File: rtl/sha256_rd_pipe.sv
`default_nettype none
// ============================================================================
// sha256_rd_pipe: MEM_LAT-deep shift of read strobes, sync clear | Rev 1.0
// ============================================================================
module sha256_rd_pipe #(
  parameter int MEM_LAT = 1
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_vld,
  output logic      o_vld
);

  logic [MEM_LAT-1:0] r_pipe;

  generate
    if (MEM_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk) begin
        if (reset) r_pipe <= '0;
        else       r_pipe <= i_vld;
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk) begin
        if (reset) r_pipe <= '0;
        else       r_pipe <= {r_pipe[MEM_LAT-2:0], i_vld};
      end
    end
  endgenerate

  assign o_vld = r_pipe[MEM_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sha256_msg_loader.sv
`default_nettype none
// ============================================================================
// sha256_msg_loader: fetches message words into a 16-word block for the core | Rev 1.0
// ============================================================================
module sha256_msg_loader
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 16,
  parameter int MEM_LAT      = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          i_start,
  input  wire logic [15:0]   i_message_addr,
  sha256_msg_loader_if.master bus,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_OF_WORDS - 1);

  ldr_state_t       r_state;
  ldr_state_t       w_state_nxt;
  logic [15:0]      r_base;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_cap_cnt;
  block_t           r_block;
  logic             r_done;
  logic             w_pipe_vld;
  logic             w_cap_fire;

  sha256_rd_pipe #(.MEM_LAT(MEM_LAT)) u_rd_pipe (
    .clk   (clk),
    .reset (reset),
    .i_vld (bus.mem_rd_en),
    .o_vld (w_pipe_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_fire  = w_pipe_vld && (r_state == S_FETCH || r_state == S_DRAIN);
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
      S_FETCH: if (r_issue_cnt == c_last_idx) w_state_nxt = S_DRAIN;
      // leave DRAIN on the edge that captures the final word
      S_DRAIN: if (w_cap_fire && r_cap_cnt == c_last_idx) w_state_nxt = S_HOLD;
      S_HOLD:  if (bus.block_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_block     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_HOLD) && bus.block_ready;
      if (r_state == S_IDLE && i_start) begin
        r_base      <= i_message_addr;
        r_issue_cnt <= '0;
        r_cap_cnt   <= '0;
        r_block     <= '0;
      end
      // issue count parks on the last index so mem_addr holds afterwards
      if (r_state == S_FETCH && r_issue_cnt != c_last_idx)
        r_issue_cnt <= r_issue_cnt + 1'b1;
      if (w_cap_fire) begin
        r_block[r_cap_cnt[3:0]] <= bus.mem_read_data;
        r_cap_cnt               <= r_cap_cnt + 1'b1;
      end
    end
  end

  assign bus.mem_rd_en   = (r_state == S_FETCH);
  assign bus.mem_addr    = r_base + 16'(r_issue_cnt);
  assign bus.block_data  = r_block;
  assign bus.block_valid = (r_state == S_HOLD);
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_loader.sv
`default_nettype none
// ============================================================================
// tb_sha256_msg_loader: directed bench over three loader configurations | Rev 1.0
// ============================================================================
module tb_sha256_msg_loader;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        start_a, start_b, start_c;
  logic [15:0] addr_a, addr_b, addr_c;
  logic        rdy_a;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  logic [15:0] wrap_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [31:0] wrap_data [4] = '{32'hA000_FEFE, 32'hA000_FEFF, 32'hA000_FF00, 32'hA000_FF01};

  sha256_msg_loader_if ifa ();
  sha256_msg_loader_if ifb ();
  sha256_msg_loader_if ifc ();

  sha256_msg_loader #(.NUM_OF_WORDS(16), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(rst), .i_start(start_a), .i_message_addr(addr_a),
    .bus(ifa.master), .o_busy(busy_a), .o_done(done_a));
  sha256_msg_loader #(.NUM_OF_WORDS(5), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(rst), .i_start(start_b), .i_message_addr(addr_b),
    .bus(ifb.master), .o_busy(busy_b), .o_done(done_b));
  sha256_msg_loader #(.NUM_OF_WORDS(4), .MEM_LAT(2)) dut_c (
    .clk(clk), .reset(rst), .i_start(start_c), .i_message_addr(addr_c),
    .bus(ifc.master), .o_busy(busy_c), .o_done(done_c));

  assign ifa.block_ready = rdy_a;
  assign ifb.block_ready = 1'b1;
  assign ifc.block_ready = 1'b1;

  // memory content: word at 0x0100+k is 0xA0000000+k, offset wraps mod 2^16
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h0100;
    return 32'hA000_0000 + {16'h0000, off};
  endfunction

  logic [31:0] md_a [4];
  logic [31:0] md_b [4];
  logic [31:0] md_c [4];
  always @(posedge clk) begin
    md_a[0] <= ifa.mem_rd_en ? mem_word(ifa.mem_addr) : 32'hDEAD_BEEF;
    md_b[0] <= ifb.mem_rd_en ? mem_word(ifb.mem_addr) : 32'hDEAD_BEEF;
    md_c[0] <= ifc.mem_rd_en ? mem_word(ifc.mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < 4; i++) begin
      md_a[i] <= md_a[i-1];
      md_b[i] <= md_b[i-1];
      md_c[i] <= md_c[i-1];
    end
  end
  assign ifa.mem_read_data = md_a[0];
  assign ifb.mem_read_data = md_b[2];
  assign ifc.mem_read_data = md_c[1];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_rd_en"}, 32'(ifa.mem_rd_en), 32'h0);
    check({tag, "_addr"},  32'(ifa.mem_addr), 32'h0);
    check({tag, "_valid"}, 32'(ifa.block_valid), 32'h0);
    check({tag, "_busy"},  32'(busy_a), 32'h0);
    check({tag, "_done"},  32'(done_a), 32'h0);
    check({tag, "_blk"},   32'(|ifa.block_data), 32'h0);
  endtask

  // 16-word load on dut_a with ready high; called at a negedge, returns on the done cycle
  task automatic load_a(input logic [15:0] base, input bit keep_start);
    start_a = 1'b1;
    addr_a  = base;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (!keep_start) start_a = 1'b0;
      if (c <= 16) check("a_addr", 32'(ifa.mem_addr), 32'(base + 16'(c - 1)));
      check("a_rd_en", 32'(ifa.mem_rd_en), 32'(c <= 16));
      check("a_valid", 32'(ifa.block_valid), 32'(c == 18));
      check("a_done",  32'(done_a), 32'(c == 19));
      if (c == 18)
        for (int k = 0; k < 16; k++)
          check("a_word", ifa.block_data[k], mem_word(base + 16'(k)));
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0;
    rdy_a = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_a("rst0");
    check("rst0_busy_b", 32'(busy_b), 32'h0);
    check("rst0_busy_c", 32'(busy_c), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // full 16-word block, latency 1
    load_a(16'h0100, 1'b0);

    // 5 words, latency 3, zero-filled tail
    start_b = 1'b1;
    addr_b  = 16'h0300;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (c <= 5) check("b_addr", 32'(ifb.mem_addr), 32'(16'h0300 + 16'(c - 1)));
      check("b_rd_en", 32'(ifb.mem_rd_en), 32'(c <= 5));
      check("b_valid", 32'(ifb.block_valid), 32'(c == 9));
      check("b_done",  32'(done_b), 32'(c == 10));
      check("b_busy",  32'(busy_b), 32'(c <= 9));
      if (c == 9)
        for (int k = 0; k < 16; k++)
          check("b_word", ifb.block_data[k], (k < 5) ? mem_word(16'h0300 + 16'(k)) : 32'h0);
    end

    // address wrap across 0xFFFF
    start_c = 1'b1;
    addr_c  = 16'hFFFE;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_c = 1'b0;
      if (c <= 4) check("c_addr", 32'(ifc.mem_addr), 32'(wrap_addr[c-1]));
      check("c_rd_en", 32'(ifc.mem_rd_en), 32'(c <= 4));
      check("c_valid", 32'(ifc.block_valid), 32'(c == 7));
      check("c_done",  32'(done_c), 32'(c == 8));
      if (c == 7)
        for (int k = 0; k < 16; k++)
          check("c_word", ifc.block_data[k], (k < 4) ? wrap_data[k] : 32'h0);
    end

    // backpressure in HOLD with a stray start
    rdy_a   = 1'b0;
    start_a = 1'b1;
    addr_a  = 16'h0400;
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk);
      start_a = (c == 20);
      if (c < 18) check("h_valid_lo", 32'(ifa.block_valid), 32'h0);
      if (c >= 18 && c <= 27) begin
        check("h_valid", 32'(ifa.block_valid), 32'h1);
        check("h_done",  32'(done_a), 32'h0);
        check("h_busy",  32'(busy_a), 32'h1);
        check("h_rd_en", 32'(ifa.mem_rd_en), 32'h0);
        check("h_w0",    ifa.block_data[0], mem_word(16'h0400));
        check("h_w15",   ifa.block_data[15], mem_word(16'h040F));
      end
      if (c == 27) rdy_a = 1'b1;
      if (c == 28) begin
        check("h_done_pulse", 32'(done_a), 32'h1);
        check("h_valid_drop", 32'(ifa.block_valid), 32'h0);
        check("h_idle_busy",  32'(busy_a), 32'h0);
      end
      if (c == 29) begin
        check("h_done_once", 32'(done_a), 32'h0);
        check("h_no_restart", 32'(busy_a), 32'h0);
        check("h_no_rd", 32'(ifa.mem_rd_en), 32'h0);
      end
    end

    // reset mid-load, then a fresh load must contain no stale data
    start_a = 1'b1;
    addr_a  = 16'h0100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (c == 8) rst = 1'b1;
    end
    @(negedge clk);
    check_reset_a("rst_mid");
    rst = 1'b0;
    load_a(16'h0200, 1'b0);

    // start held high: back-to-back loads
    load_a(16'h0500, 1'b1);
    load_a(16'h0600, 1'b1);
    start_a = 1'b0;
    @(negedge clk);
    check("bb_idle_busy", 32'(busy_a), 32'h0);
    check("bb_idle_rd",   32'(ifa.mem_rd_en), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
